// File: rtl/clk_pkg.sv
// Shared definitions for the real-time clock core: field width, the
// seconds/minutes limit, register addresses and a write-value check.
package clk_pkg;

    localparam int FIELD_W = 6;

    localparam logic [FIELD_W-1:0] MAX_SEC_MIN = 6'd59;

    // Write-target addresses; the two upper codes are reserved.
    typedef enum logic [1:0] {
        ADDR_SEC  = 2'b00,
        ADDR_MIN  = 2'b01,
        ADDR_RSV2 = 2'b10,
        ADDR_RSV3 = 2'b11
    } addr_e;

    // A written value is only accepted if it is a legal time field (0..59).
    function automatic logic value_ok(input logic [FIELD_W-1:0] v);
        return (v <= MAX_SEC_MIN);
    endfunction

endpackage : clk_pkg

// File: rtl/mod60_counter.sv
// Modulo-60 counter with synchronous load. Load has priority over count
// enable; carry flags a 59 -> 0 wrap that is not overridden by a load.
module mod60_counter
    import clk_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               ld,
    input  logic [FIELD_W-1:0] d,
    output logic [FIELD_W-1:0] q,
    output logic               carry
);

    logic [FIELD_W-1:0] q_r;
    logic [FIELD_W-1:0] q_next_s;
    logic               at_max_s;

    assign at_max_s = (q_r == MAX_SEC_MIN);

    // Next-value selection: load, else count with wrap, else hold.
    always_comb begin
        q_next_s = q_r;
        if (ld) begin
            q_next_s = d;
        end else if (en) begin
            if (at_max_s) begin
                q_next_s = {FIELD_W{1'b0}};
            end else begin
                q_next_s = q_r + 6'd1;
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Counter state register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= {FIELD_W{1'b0}};
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q     = q_r;
    assign carry = en & at_max_s & ~ld;

endmodule : mod60_counter

// File: rtl/top_clk_v3_core.sv
// Real-time clock core: a prescaler turns the system clock into a 1-cycle
// tick every TICK_DIV cycles, which drives cascaded mod-60 seconds and
// minutes counters. Either field can be written through a small
// address/data port; a seconds write also restarts the prescaler phase.
module top_clk_v3_core
    import clk_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_DIV    = CLK_FREQ_HZ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [1:0]         addrs,
    input  logic [FIELD_W-1:0] data_in,
    output logic [FIELD_W-1:0] seconds_out,
    output logic [FIELD_W-1:0] minutes_out
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler_r;
    logic          tick_s;
    logic          ld_sec_s;
    logic          ld_min_s;
    logic          sec_carry_s;
    logic          min_carry_unused_s;

    // Decode the write strobe; out-of-range data and reserved addresses
    // produce no load at all.
    always_comb begin
        ld_sec_s = 1'b0;
        ld_min_s = 1'b0;
        if (load && value_ok(data_in)) begin
            case (addrs)
                ADDR_SEC: ld_sec_s = 1'b1;
                ADDR_MIN: ld_min_s = 1'b1;
                default: begin
                    ld_sec_s = 1'b0;
                    ld_min_s = 1'b0;
                end
            endcase
        end else begin
            ld_sec_s = 1'b0;
            ld_min_s = 1'b0;
        end
    end

    assign tick_s = (prescaler_r == TICK_LAST);

    // Prescaler: free-running 0..TICK_DIV-1, restarted by a seconds write so
    // the next tick lands a full period after the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_r <= {PW{1'b0}};
        end else if (ld_sec_s || tick_s) begin
            prescaler_r <= {PW{1'b0}};
        end else begin
            prescaler_r <= prescaler_r + PW'(1);
        end
    end

    mod60_counter u_seconds (
        .clk   (clk),
        .reset (reset),
        .en    (tick_s),
        .ld    (ld_sec_s),
        .d     (data_in),
        .q     (seconds_out),
        .carry (sec_carry_s)
    );

    // Minutes advance on the seconds wrap; their own wrap has no consumer.
    mod60_counter u_minutes (
        .clk   (clk),
        .reset (reset),
        .en    (sec_carry_s),
        .ld    (ld_min_s),
        .d     (data_in),
        .q     (minutes_out),
        .carry (min_carry_unused_s)
    );

endmodule : top_clk_v3_core

// File: tb/tb_top_clk_v3_core.sv
// Scoreboard bench for top_clk_v3_core with TICK_DIV = 10. A reference
// model computes the expected outputs whenever stimulus is driven and
// pushes them to a queue; they are popped and compared after the edge.
module tb_top_clk_v3_core;

    localparam int DIV = 10;

    logic       clk;
    logic       reset;
    logic       load;
    logic [1:0] addrs;
    logic [5:0] data_in;
    logic [5:0] seconds_out;
    logic [5:0] minutes_out;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_pre;
    int m_sec;
    int m_min;

    logic [11:0] exp_q[$];

    top_clk_v3_core #(.CLK_FREQ_HZ(100), .TICK_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .addrs       (addrs),
        .data_in     (data_in),
        .seconds_out (seconds_out),
        .minutes_out (minutes_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        m_sec = 0;
        m_min = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, predict, wait past the edge, compare.
    task automatic cycle(input logic ld, input logic [1:0] a, input logic [5:0] d);
        logic tick;
        logic ls;
        logic lm;
        logic carry;
        logic [11:0] e;
        load    = ld;
        addrs   = a;
        data_in = d;
        tick  = (m_pre == DIV - 1);
        ls    = ld && (a == 2'b00) && (d <= 6'd59);
        lm    = ld && (a == 2'b01) && (d <= 6'd59);
        carry = tick && (m_sec == 59) && !ls;
        m_pre = (ls || tick) ? 0 : m_pre + 1;
        if (ls)        m_sec = int'(d);
        else if (tick) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
        if (lm)         m_min = int'(d);
        else if (carry) m_min = (m_min == 59) ? 0 : m_min + 1;
        exp_q.push_back({6'(m_sec), 6'(m_min)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("sb_sec", int'(seconds_out), int'(e[11:6]));
        check_val("sb_min", int'(minutes_out), int'(e[5:0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 6'd0);
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        addrs   = 2'b00;
        data_in = 6'd0;
        model_reset();
        #100;
        check_val("reset_sec", int'(seconds_out), 0);
        check_val("reset_min", int'(minutes_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Free run: first tick after exactly DIV cycles, one minute at 600.
        idle(9);
        check_val("pre_first_tick", int'(seconds_out), 0);
        idle(1);
        check_val("first_tick", int'(seconds_out), 1);
        idle(590);
        check_val("run600_sec", int'(seconds_out), 0);
        check_val("run600_min", int'(minutes_out), 1);

        // Minutes write leaves seconds counting on the same phase.
        cycle(1'b1, 2'b01, 6'd40);
        check_val("ld_min", int'(minutes_out), 40);
        idle(9);
        check_val("sec_after_ld_min", int'(seconds_out), 1);

        // Seconds write 58: restarts phase, rolls into next minute.
        cycle(1'b1, 2'b00, 6'd58);
        idle(9);
        check_val("ld58_hold", int'(seconds_out), 58);
        idle(1);
        check_val("ld58_tick", int'(seconds_out), 59);
        idle(10);
        check_val("roll_sec", int'(seconds_out), 0);
        check_val("roll_min", int'(minutes_out), 41);

        // Minute wrap 59:59 -> 00:00.
        cycle(1'b1, 2'b01, 6'd59);
        cycle(1'b1, 2'b00, 6'd59);
        idle(10);
        check_val("wrap_sec", int'(seconds_out), 0);
        check_val("wrap_min", int'(minutes_out), 0);

        // Invalid writes and a zero-width glitch change nothing.
        idle(3);
        cycle(1'b1, 2'b00, 6'd60);
        cycle(1'b1, 2'b01, 6'd60);
        cycle(1'b1, 2'b10, 6'd5);
        cycle(1'b1, 2'b11, 6'd7);
        load = 1'b1; addrs = 2'b00; data_in = 6'd33;
        #2;
        load = 1'b0;
        idle(3);
        check_val("inv_sec", int'(seconds_out), 1);
        check_val("inv_min", int'(minutes_out), 0);

        // Minutes write while seconds wraps: both take effect.
        cycle(1'b1, 2'b00, 6'd59);
        idle(9);
        cycle(1'b1, 2'b01, 6'd12);
        check_val("sim_min_ld_sec", int'(seconds_out), 0);
        check_val("sim_min_ld_min", int'(minutes_out), 12);

        // Seconds write on a wrap tick suppresses the carry.
        cycle(1'b1, 2'b00, 6'd59);
        idle(9);
        cycle(1'b1, 2'b00, 6'd5);
        check_val("sim_sec_ld_sec", int'(seconds_out), 5);
        check_val("sim_sec_ld_min", int'(minutes_out), 12);

        // Held seconds write freezes time.
        for (int i = 0; i < 25; i++) cycle(1'b1, 2'b00, 6'd20);
        check_val("held_sec", int'(seconds_out), 20);
        idle(10);
        check_val("held_release", int'(seconds_out), 21);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 63)));
        end

        // Asynchronous reset between edges at seconds = 37.
        cycle(1'b1, 2'b00, 6'd37);
        idle(2);
        check_val("pre_arst_sec", int'(seconds_out), 37);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_sec", int'(seconds_out), 0);
        check_val("arst_min", int'(minutes_out), 0);
        model_reset();
        // Load is ignored while reset is held.
        load = 1'b1; addrs = 2'b01; data_in = 6'd9;
        @(posedge clk);
        #1;
        check_val("rst_ld_min", int'(minutes_out), 0);
        load  = 1'b0;
        reset = 1'b0;
        idle(10);
        check_val("post_rst_tick", int'(seconds_out), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_top_clk_v3_core
